// File: rtl/lcd_pattern_sched.sv
// Test-pattern sequencer for the LCD pixel generator: derives bar width by
// repeated subtraction and steps the active pattern only at frame boundaries.
module lcd_pattern_sched #(
  parameter int unsigned NUM_PAT        = 4,
  parameter int unsigned FRAMES_PER_PAT = 120,
  parameter int unsigned NUM_BARS       = 5
) (
  input  logic        lcd_pclk,
  input  logic        rst,
  input  logic [10:0] pixel_xpos,
  input  logic [10:0] pixel_ypos,
  input  logic [10:0] h_disp,
  input  logic [10:0] v_disp,
  input  logic        auto_en,
  input  logic        next_req,
  output logic [2:0]  pattern_sel,
  output logic        pattern_upd,
  output logic [10:0] bar_w,
  output logic        cfg_valid,
  output logic        frame_done,
  output logic [7:0]  frame_cnt
);

  localparam int unsigned POS_W = 11;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned CNT_W = 8;

  localparam logic [POS_W-1:0] BARS       = POS_W'(NUM_BARS);
  localparam logic [SEL_W-1:0] LAST_PAT   = SEL_W'(NUM_PAT - 1);
  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(FRAMES_PER_PAT - 1);

  typedef enum logic {
    CALC = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state, state_d;
  logic               calc_first, calc_first_d;
  logic [POS_W-1:0]   rem, rem_d;
  logic [POS_W-1:0]   quo, quo_d;
  logic [POS_W-1:0]   h_reg, h_reg_d;
  logic [POS_W-1:0]   bar_w_d;
  logic               cfg_valid_d;
  logic               hit, hit_q;
  logic               frame_done_d;
  logic               pattern_upd_d;
  logic [SEL_W-1:0]   pattern_sel_d;
  logic [CNT_W-1:0]   frame_cnt_d;
  logic               pending, pending_d;
  logic               boundary;
  logic               advance;

  // Last active pixel of the frame; wraps harmlessly when a resolution is zero.
  assign hit = (pixel_xpos == (h_disp - POS_W'(1))) &&
               (pixel_ypos == (v_disp - POS_W'(1)));

  // A boundary only counts while geometry is settled for the current h_disp.
  assign boundary = hit && !hit_q && (state == RUN) && (h_disp == h_reg);
  assign advance  = pending || next_req || (auto_en && (frame_cnt == LAST_FRAME));

  // Next-state and output logic: bar-width divider plus pattern sequencing.
  always_comb begin
    state_d       = state;
    calc_first_d  = calc_first;
    rem_d         = rem;
    quo_d         = quo;
    h_reg_d       = h_reg;
    bar_w_d       = bar_w;
    cfg_valid_d   = cfg_valid;
    frame_done_d  = boundary;
    pattern_upd_d = 1'b0;
    pattern_sel_d = pattern_sel;
    frame_cnt_d   = frame_cnt;
    pending_d     = pending | next_req;

    case (state)
      CALC: begin
        if (calc_first) begin
          rem_d        = h_disp;
          quo_d        = '0;
          h_reg_d      = h_disp;
          cfg_valid_d  = 1'b0;
          calc_first_d = 1'b0;
        end else if (h_disp != h_reg) begin
          calc_first_d = 1'b1;
        end else if (rem >= BARS) begin
          rem_d = rem - BARS;
          quo_d = quo + POS_W'(1);
        end else begin
          bar_w_d     = quo;
          cfg_valid_d = 1'b1;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (h_disp != h_reg) begin
          cfg_valid_d  = 1'b0;
          calc_first_d = 1'b1;
          state_d      = CALC;
        end
      end
      default: begin
        calc_first_d = 1'b1;
        state_d      = CALC;
      end
    endcase

    // Requests and auto expiry in the same frame collapse into one advance.
    if (boundary) begin
      if (advance) begin
        pattern_upd_d = 1'b1;
        pattern_sel_d = (pattern_sel >= LAST_PAT) ? '0 : pattern_sel + SEL_W'(1);
        frame_cnt_d   = '0;
        pending_d     = 1'b0;
      end else begin
        frame_cnt_d = auto_en ? frame_cnt + CNT_W'(1) : '0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge lcd_pclk) begin
    if (rst) begin
      state       <= CALC;
      calc_first  <= 1'b1;
      rem         <= '0;
      quo         <= '0;
      h_reg       <= '0;
      bar_w       <= '0;
      cfg_valid   <= 1'b0;
      hit_q       <= 1'b0;
      frame_done  <= 1'b0;
      pattern_upd <= 1'b0;
      pattern_sel <= '0;
      frame_cnt   <= '0;
      pending     <= 1'b0;
    end else begin
      state       <= state_d;
      calc_first  <= calc_first_d;
      rem         <= rem_d;
      quo         <= quo_d;
      h_reg       <= h_reg_d;
      bar_w       <= bar_w_d;
      cfg_valid   <= cfg_valid_d;
      hit_q       <= hit;
      frame_done  <= frame_done_d;
      pattern_upd <= pattern_upd_d;
      pattern_sel <= pattern_sel_d;
      frame_cnt   <= frame_cnt_d;
      pending     <= pending_d;
    end
  end

endmodule

// File: tb/tb_lcd_pattern_sched.sv
// Self-checking bench for lcd_pattern_sched: geometry table, directed frame
// sequences and randomized traffic against a behavioural model.
module tb_lcd_pattern_sched;

  localparam int unsigned NP  = 4;
  localparam int unsigned FPP = 3;
  localparam int unsigned NB  = 5;

  logic        lcd_pclk = 1'b0;
  logic        rst;
  logic [10:0] pixel_xpos, pixel_ypos, h_disp, v_disp;
  logic        auto_en, next_req;
  logic [2:0]  pattern_sel;
  logic        pattern_upd;
  logic [10:0] bar_w;
  logic        cfg_valid;
  logic        frame_done;
  logic [7:0]  frame_cnt;

  lcd_pattern_sched #(
    .NUM_PAT(NP), .FRAMES_PER_PAT(FPP), .NUM_BARS(NB)
  ) dut (
    .lcd_pclk(lcd_pclk), .rst(rst),
    .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
    .h_disp(h_disp), .v_disp(v_disp),
    .auto_en(auto_en), .next_req(next_req),
    .pattern_sel(pattern_sel), .pattern_upd(pattern_upd),
    .bar_w(bar_w), .cfg_valid(cfg_valid),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 lcd_pclk = ~lcd_pclk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: bar width is h/NB, ready h/NB+2 cycles after CALC entry.
  bit          m_calc, m_first, m_valid, m_hit_prev, m_fd, m_upd, m_pend;
  int          m_left, m_sel, m_cnt;
  logic [10:0] m_hreg, m_bar_w;

  task automatic model_edge();
    logic [10:0] hm1, vm1;
    bit hit_now;
    if (rst) begin
      m_calc = 1; m_first = 1; m_valid = 0; m_hit_prev = 0; m_fd = 0; m_upd = 0;
      m_pend = 0; m_left = 0; m_sel = 0; m_cnt = 0; m_hreg = '0; m_bar_w = '0;
      return;
    end
    hm1 = h_disp - 11'd1;
    vm1 = v_disp - 11'd1;
    hit_now = (pixel_xpos == hm1) && (pixel_ypos == vm1);
    m_fd  = hit_now && !m_hit_prev && !m_calc && (h_disp == m_hreg);
    m_upd = 0;
    if (m_fd) begin
      if (m_pend || next_req || (auto_en && m_cnt == int'(FPP) - 1)) begin
        m_sel = (m_sel + 1) % int'(NP);
        m_upd = 1; m_cnt = 0; m_pend = 0;
      end else begin
        m_cnt = auto_en ? (m_cnt + 1) % 256 : 0;
      end
    end else if (next_req) begin
      m_pend = 1;
    end
    m_hit_prev = hit_now;
    if (m_calc) begin
      if (m_first) begin
        m_hreg = h_disp; m_left = int'(h_disp) / int'(NB) + 1; m_valid = 0; m_first = 0;
      end else if (h_disp != m_hreg) begin
        m_first = 1;
      end else if (m_left == 1) begin
        m_bar_w = 11'(int'(m_hreg) / int'(NB)); m_valid = 1; m_calc = 0;
      end else begin
        m_left--;
      end
    end else if (h_disp != m_hreg) begin
      m_valid = 0; m_calc = 1; m_first = 1;
    end
  endtask

  task automatic step();
    @(posedge lcd_pclk);
    model_edge();
    #1;
    check("outputs{sel,upd,bar_w,valid,fd,cnt}",
          {pattern_sel, pattern_upd, bar_w, cfg_valid, frame_done, frame_cnt},
          {3'(m_sel), m_upd, m_bar_w, m_valid, m_fd, 8'(m_cnt)});
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
  endtask

  task automatic wait_valid(output int n, output bit fd_seen);
    n = 0; fd_seen = 0;
    while (!cfg_valid && n < 4000) begin
      step(); n++;
      if (frame_done) fd_seen = 1;
    end
  endtask

  typedef struct {
    logic [10:0] h;
    logic [10:0] exp_bar;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];
  int   n, fcount, upd_in, exp_upd, fd_cnt;
  bit   fd_seen, held_ok;
  int   upd_frames[$];
  int   upd_sels[$];
  logic [10:0] hs[6];

  initial begin
    vecs[0] = '{11'd480,  11'd96,  98};
    vecs[1] = '{11'd800,  11'd160, 162};
    vecs[2] = '{11'd0,    11'd0,   2};
    vecs[3] = '{11'd4,    11'd0,   2};
    vecs[4] = '{11'd5,    11'd1,   3};
    vecs[5] = '{11'd7,    11'd1,   3};
    vecs[6] = '{11'd10,   11'd2,   4};
    vecs[7] = '{11'd2047, 11'd409, 411};
    hs = '{11'd8, 11'd12, 11'd0, 11'd3, 11'd20, 11'd37};

    rst = 1'b1; pixel_xpos = '0; pixel_ypos = '0; h_disp = 11'd480; v_disp = 11'd4;
    auto_en = 1'b0; next_req = 1'b0;

    // Geometry table: latency from reset release and truncated quotient.
    for (int i = 0; i < 8; i++) begin
      h_disp = vecs[i].h;
      do_reset();
      check("reset_valid", cfg_valid, 0);
      wait_valid(n, fd_seen);
      check("calc_latency", n, vecs[i].exp_lat);
      check("bar_w", bar_w, vecs[i].exp_bar);
      check("fd_during_calc", fd_seen, 0);
    end

    // Auto cycling on a tiny 8x4 raster.
    h_disp = 11'd8; v_disp = 11'd4; auto_en = 1'b1; pixel_xpos = '0; pixel_ypos = '0;
    do_reset();
    wait_valid(n, fd_seen);
    fcount = 0;
    for (int f = 0; f < 12; f++)
      for (int y = 0; y < 4; y++)
        for (int x = 0; x < 8; x++) begin
          pixel_xpos = 11'(x); pixel_ypos = 11'(y);
          step();
          if (frame_done) fcount++;
          if (pattern_upd) begin
            upd_frames.push_back(fcount);
            upd_sels.push_back(int'(pattern_sel));
          end
        end
    check("auto_frames", fcount, 12);
    check("auto_upd_count", upd_frames.size(), 4);
    for (int k = 0; k < 4 && k < upd_frames.size(); k++) begin
      check("auto_upd_frame", upd_frames[k], (k + 1) * 3);
      check("auto_upd_sel", upd_sels[k], (k + 1) % 4);
    end

    // Manual requests: coalescing within a frame, and a request on the boundary cycle.
    auto_en = 1'b0; pixel_xpos = '0; pixel_ypos = '0;
    do_reset();
    wait_valid(n, fd_seen);
    for (int f = 0; f < 4; f++) begin
      upd_in = 0;
      for (int y = 0; y < 4; y++)
        for (int x = 0; x < 8; x++) begin
          pixel_xpos = 11'(x); pixel_ypos = 11'(y);
          next_req = (f == 0 && y == 0 && (x == 1 || x == 3 || x == 5)) ||
                     (f == 2 && x == 7 && y == 3);
          step();
          if (pattern_upd) upd_in++;
        end
      next_req = 1'b0;
      exp_upd = (f == 0 || f == 2) ? 1 : 0;
      check("req_upd_per_frame", upd_in, exp_upd);
    end
    check("req_final_sel", pattern_sel, 2);

    // Resolution change while running: valid drops, old bar width held.
    h_disp = 11'd480; pixel_xpos = '0; pixel_ypos = '0;
    do_reset();
    wait_valid(n, fd_seen);
    check("bar_480", bar_w, 96);
    repeat (5) step();
    h_disp = 11'd800;
    step();
    check("cfg_drop", cfg_valid, 0);
    check("bar_hold_first", bar_w, 96);
    n = 1; held_ok = 1; fd_seen = 0;
    while (!cfg_valid && n < 4000) begin
      pixel_xpos = (n % 2) ? 11'd799 : 11'd0;
      pixel_ypos = (n % 2) ? 11'd3 : 11'd0;
      step(); n++;
      if (!cfg_valid && bar_w != 11'd96) held_ok = 0;
      if (frame_done) fd_seen = 1;
    end
    check("recalc_latency", n, 163);
    check("bar_800", bar_w, 160);
    check("bar_held_in_calc", held_ok, 1);
    check("no_fd_in_calc", fd_seen, 0);

    // Frozen boundary position, then reset in the middle of CALC.
    auto_en = 1'b1; pixel_xpos = '0; pixel_ypos = '0;
    step();
    pixel_xpos = 11'd799; pixel_ypos = 11'd3;
    fd_cnt = 0;
    repeat (10) begin
      step();
      if (frame_done) fd_cnt++;
    end
    check("frozen_single_fd", fd_cnt, 1);
    check("frozen_cnt", frame_cnt, 1);
    pixel_xpos = '0; pixel_ypos = '0;
    next_req = 1'b1; step(); next_req = 1'b0;
    h_disp = 11'd480;
    repeat (20) step();
    rst = 1'b1;
    step();
    check("rst_sel", pattern_sel, 0);
    check("rst_upd", pattern_upd, 0);
    check("rst_bar_w", bar_w, 0);
    check("rst_valid", cfg_valid, 0);
    check("rst_fd", frame_done, 0);
    check("rst_cnt", frame_cnt, 0);
    rst = 1'b0; auto_en = 1'b0;
    wait_valid(n, fd_seen);
    check("post_rst_latency", n, 98);
    pixel_xpos = 11'd479; pixel_ypos = 11'd3;
    step();
    check("post_rst_fd", frame_done, 1);
    check("pending_cleared", pattern_upd, 0);

    // Randomized traffic against the model.
    pixel_xpos = '0; pixel_ypos = '0; h_disp = hs[0];
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 199) == 0) h_disp = hs[$urandom_range(0, 5)];
      if ($urandom_range(0, 299) == 0) v_disp = 11'($urandom_range(0, 6));
      if ($urandom_range(0, 63) == 0) auto_en = ~auto_en;
      next_req = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) begin
        pixel_xpos = h_disp - 11'd1;
        pixel_ypos = v_disp - 11'd1;
      end else if ($urandom_range(0, 1) == 0) begin
        pixel_xpos = 11'($urandom_range(0, 40));
        pixel_ypos = 11'($urandom_range(0, 6));
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
